mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 59 +++++
 rtl/mem_arbiter_store_fifo.sv | 63 ++++++
 rtl/mem_arbiter.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared defines for the memory arbiter: op encodings, MSB depth, FSM states,
// store-buffer entry layout and small decode/extend helpers.
package mem_arbiter_pkg;

  localparam logic True  = 1'b1;
  localparam logic False = 1'b0;

  localparam int OpIdW = 4;
  typedef logic [OpIdW-1:0] OpIdBus;

  localparam OpIdBus OP_LB  = 4'd1;
  localparam OpIdBus OP_LH  = 4'd2;
  localparam OpIdBus OP_LW  = 4'd3;
  localparam OpIdBus OP_LBU = 4'd4;
  localparam OpIdBus OP_LHU = 4'd5;
  localparam OpIdBus OP_SB  = 4'd6;
  localparam OpIdBus OP_SH  = 4'd7;
  localparam OpIdBus OP_SW  = 4'd8;

  localparam int MSB_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2,
    STORE = 2'd3
  } arb_state_e;

  typedef struct packed {
    OpIdBus      op;
    logic [31:0] addr;
    logic [31:0] data;
  } msb_entry_t;

  // Number of bytes moved by a load/store op.
  function automatic logic [2:0] op_bytes(input OpIdBus op);
    logic [2:0] n;
    case (op)
      OP_LB, OP_LBU, OP_SB: n = 3'd1;
      OP_LH, OP_LHU, OP_SH: n = 3'd2;
      default:              n = 3'd4;
    endcase
    return n;
  endfunction

  // Sign- or zero-extend the assembled little-endian bytes of a load.
  function automatic logic [31:0] load_extend(input OpIdBus op, input logic [31:0] raw);
    logic [31:0] v;
    case (op)
      OP_LB:   v = {{24{raw[7]}}, raw[7:0]};
      OP_LBU:  v = {24'h000000, raw[7:0]};
      OP_LH:   v = {{16{raw[15]}}, raw[15:0]};
      OP_LHU:  v = {16'h0000, raw[15:0]};
      default: v = raw;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/mem_arbiter_store_fifo.sv
// Committed-store buffer (MSB): small FIFO of {op, addr, data} entries.
// Pushes into a full buffer are dropped; push+pop together keep the count.
module store_fifo
  import mem_arbiter_pkg::*;
#(
  parameter int DEPTH = MSB_DEPTH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       push,
  input  logic       pop,
  input  msb_entry_t push_entry,
  output logic       full,
  output logic       empty,
  output msb_entry_t head
);

  localparam int          PW        = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_CNT = (PW+1)'(DEPTH);
  localparam logic [PW:0] CNT_ONE   = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  msb_entry_t    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q, count_d;
  logic          full_q;
  logic          do_push, do_pop;

  assign do_push = en & push & ~full_q;
  assign do_pop  = en & pop & (count_q != '0);
  assign full    = full_q;
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];

  // Next occupancy from the accepted push/pop pair.
  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + CNT_ONE;
    else if (do_pop && !do_push) count_d = count_q - CNT_ONE;
  end

  // Pointers, count and registered full flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= False;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_d;
      full_q  <= (count_d == DEPTH_CNT);
    end
  end

  // Entry storage; contents only matter while counted as valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Byte-serial memory arbiter sharing one 8-bit RAM port between instruction
// fetch, data loads and the committed-store buffer.
//
//   state | meaning
//   IDLE  | arbitration cycle, picks the next access
//   FETCH | 4-byte instruction read, pulses if_done
//   LOAD  | 1/2/4-byte data read, pulses ld_done with extended value
//   STORE | writes the MSB head entry, pops it on its last byte
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clr,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        ld_req,
  input  OpIdBus      ld_op,
  input  logic [31:0] ld_addr,
  output logic        ld_done,
  output logic [31:0] ld_value,
  input  logic        st_push,
  input  OpIdBus      st_op,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        msb_full,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr
);

  arb_state_e  state_q, grant;
  logic [2:0]  cnt_q, nbytes_q;
  logic [31:0] asm_q, asm_d;
  logic        pend_q;
  OpIdBus      pend_op_q;
  logic [31:0] pend_addr_q;
  logic        if_done_q, ld_done_q, mem_wr_q;
  logic [31:0] if_data_q, ld_value_q, mem_a_q;
  logic [7:0]  mem_dout_q;
  logic        rdy_q;
  logic [7:0]  din_hold_q, din_eff;
  logic [1:0]  nxt_idx;
  logic        fifo_full, fifo_empty, fifo_pop;
  msb_entry_t  fifo_head, fifo_in;

  assign fifo_in  = '{op: st_op, addr: st_addr, data: st_data};
  assign fifo_pop = (state_q == STORE) && (cnt_q == nbytes_q - 3'd1);

  store_fifo #(.DEPTH(MSB_DEPTH)) u_msb (
    .clk       (clk),
    .rst       (rst),
    .en        (rdy),
    .push      (st_push),
    .pop       (fifo_pop),
    .push_entry(fifo_in),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  // The RAM keeps answering while we are frozen, so the byte that arrived in
  // the first frozen cycle is parked and used once rdy returns.
  assign din_eff = rdy_q ? mem_din : din_hold_q;
  assign nxt_idx = cnt_q[1:0] + 2'd1;

  assign if_done  = if_done_q & rdy;
  assign ld_done  = ld_done_q & rdy;
  assign if_data  = if_data_q;
  assign ld_value = ld_value_q;
  assign msb_full = fifo_full;
  assign mem_a    = mem_a_q;
  assign mem_dout = mem_dout_q;
  assign mem_wr   = mem_wr_q & rdy;

  // Merge the byte arriving this cycle (byte cnt-1) into the read word.
  always_comb begin
    asm_d = asm_q;
    case (cnt_q)
      3'd1:    asm_d[7:0]   = din_eff;
      3'd2:    asm_d[15:8]  = din_eff;
      3'd3:    asm_d[23:16] = din_eff;
      3'd4:    asm_d[31:24] = din_eff;
      default: ;
    endcase
  end

  // Arbitration. Stores drain ahead of a pending load so no load passes an
  // older store; a flush cycle never starts a read.
  always_comb begin
    grant = IDLE;
    if (!fifo_empty && ((pend_q && !clr) || fifo_full)) grant = STORE;
    else if (clr)                                      grant = fifo_empty ? IDLE : STORE;
    else if (pend_q)                                   grant = LOAD;
    else if (if_req)                                   grant = FETCH;
    else if (!fifo_empty)                              grant = STORE;
  end

  // Track previous rdy and park the RAM byte on entry to a freeze.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_q      <= True;
      din_hold_q <= '0;
    end else begin
      rdy_q <= rdy;
      if (rdy_q) din_hold_q <= mem_din;
    end
  end

  // Main FSM with pending-load register and registered RAM/result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      nbytes_q    <= '0;
      asm_q       <= '0;
      pend_q      <= False;
      pend_op_q   <= '0;
      pend_addr_q <= '0;
      if_done_q   <= False;
      ld_done_q   <= False;
      if_data_q   <= '0;
      ld_value_q  <= '0;
      mem_a_q     <= '0;
      mem_dout_q  <= '0;
      mem_wr_q    <= False;
    end else if (rdy) begin
      if_done_q <= False;
      ld_done_q <= False;

      if (clr) begin
        pend_q <= False;
      end else if (ld_req && !pend_q) begin
        pend_q      <= True;
        pend_op_q   <= ld_op;
        pend_addr_q <= ld_addr;
      end

      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          asm_q <= '0;
          case (grant)
            FETCH: begin
              mem_a_q  <= if_addr;
              nbytes_q <= 3'd4;
            end
            LOAD: begin
              mem_a_q  <= pend_addr_q;
              nbytes_q <= op_bytes(pend_op_q);
            end
            STORE: begin
              mem_a_q    <= fifo_head.addr;
              mem_dout_q <= fifo_head.data[7:0];
              mem_wr_q   <= True;
              nbytes_q   <= op_bytes(fifo_head.op);
            end
            default: ;
          endcase
          state_q <= grant;
        end

        FETCH, LOAD: begin
          asm_q <= asm_d;
          if (clr) begin
            state_q <= IDLE;
          end else if (cnt_q == nbytes_q) begin
            state_q <= IDLE;
            if (state_q == FETCH) begin
              if_done_q <= True;
              if_data_q <= asm_d;
            end else begin
              ld_done_q  <= True;
              ld_value_q <= load_extend(pend_op_q, asm_d);
              pend_q     <= False;
            end
          end else begin
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q + 3'd1 < nbytes_q) mem_a_q <= mem_a_q + 32'd1;
          end
        end

        STORE: begin
          if (cnt_q == nbytes_q - 3'd1) begin
            mem_wr_q <= False;
            state_q  <= IDLE;
          end else begin
            cnt_q      <= cnt_q + 3'd1;
            mem_a_q    <= mem_a_q + 32'd1;
            mem_dout_q <= fifo_head.data[{nxt_idx, 3'b000} +: 8];
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
